sdf_bf_stage: RTL and testbench

SDF_BF_STAGE -- requirements
Module: sdf_bf_stage

---
 rtl/sdf_bf_stage_pkg.sv | 18 +
 rtl/cmul_q8.sv | 37 +++
 rtl/sdf_bf_stage.sv | 98 +++++++++
 tb/tb_sdf_bf_stage.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdf_bf_stage_pkg.sv
// Shared FFT definitions: word format, controller phase encodings and
// common Q8 twiddle constants.
package sdf_bf_stage_pkg;

   localparam int W    = 24;
   localparam int FRAC = 8;

   typedef enum logic [1:0] {
      PRIME  = 2'd0,
      ROTATE = 2'd1,
      BFLY   = 2'd2,
      RSVD   = 2'd3
   } state_t;

   localparam logic [W-1:0] ONE     = 24'h000100;
   localparam logic [W-1:0] NEG_ONE = 24'hFFFF00;

endpackage

// File: rtl/cmul_q8.sv
// Combinational complex multiply in Q(W-8).8: full-width products, sum before
// an arithmetic shift, then truncation back to W bits without rounding.
module cmul_q8
   import sdf_bf_stage_pkg::*;
#(
   parameter int W = sdf_bf_stage_pkg::W
) (
   input  logic signed [W-1:0] a_r,
   input  logic signed [W-1:0] a_i,
   input  logic signed [W-1:0] w_r,
   input  logic signed [W-1:0] w_i,
   output logic signed [W-1:0] p_r,
   output logic signed [W-1:0] p_i
);

   logic signed [2*W-1:0] ar_x, ai_x, wr_x, wi_x;
   logic signed [2*W-1:0] rr, ii, ri, ir;
   logic signed [2*W-1:0] sum_r, sum_i;

   // Explicit sign extension keeps every product at the full 2W width.
   assign ar_x = {{W{a_r[W-1]}}, a_r};
   assign ai_x = {{W{a_i[W-1]}}, a_i};
   assign wr_x = {{W{w_r[W-1]}}, w_r};
   assign wi_x = {{W{w_i[W-1]}}, w_i};

   assign rr = ar_x * wr_x;
   assign ii = ai_x * wi_x;
   assign ri = ar_x * wi_x;
   assign ir = ai_x * wr_x;

   assign sum_r = rr - ii;
   assign sum_i = ri + ir;

   assign p_r = W'(sum_r >>> FRAC);
   assign p_i = W'(sum_i >>> FRAC);

endmodule

// File: rtl/sdf_bf_stage.sv
// Single-path delay-feedback radix-2 stage: a DELAY-deep complex shift chain
// feeding either a butterfly or a twiddle rotation, one sample per valid cycle.
module sdf_bf_stage
   import sdf_bf_stage_pkg::*;
#(
   parameter int DELAY = 2,
   parameter int W     = sdf_bf_stage_pkg::W
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in_valid,
   input  logic signed [W-1:0] din_r,
   input  logic signed [W-1:0] din_i,
   input  logic        [1:0]   state,
   input  logic signed [W-1:0] w_r,
   input  logic signed [W-1:0] w_i,
   output logic                out_valid,
   output logic signed [W-1:0] dout_r,
   output logic signed [W-1:0] dout_i
);

   logic signed [W-1:0] dl_r [DELAY];
   logic signed [W-1:0] dl_i [DELAY];

   logic signed [W-1:0] a_r, a_i;
   logic signed [W-1:0] prod_r, prod_i;
   logic signed [W-1:0] push_r, push_i;
   logic signed [W-1:0] nxt_r, nxt_i;
   logic                nxt_valid;
   state_t              phase;

   assign phase = state_t'(state);
   assign a_r   = dl_r[DELAY-1];
   assign a_i   = dl_i[DELAY-1];

   cmul_q8 #(.W(W)) u_cmul (
      .a_r (a_r),
      .a_i (a_i),
      .w_r (w_r),
      .w_i (w_i),
      .p_r (prod_r),
      .p_i (prod_i)
   );

   always_comb begin
      // NOTE: every output gets a default before the case so no latch is inferred.
      push_r    = din_r;
      push_i    = din_i;
      nxt_r     = dout_r;
      nxt_i     = dout_i;
      nxt_valid = 1'b0;
      case (phase)
         BFLY: begin
            nxt_r     = a_r + din_r;
            nxt_i     = a_i + din_i;
            push_r    = a_r - din_r;
            push_i    = a_i - din_i;
            nxt_valid = 1'b1;
         end
         ROTATE: begin
            nxt_r     = prod_r;
            nxt_i     = prod_i;
            nxt_valid = 1'b1;
         end
         default: ;  // PRIME and the reserved code only load the delay line
      endcase
   end

   // NOTE: the delay line is a plain register chain, not a RAM, so clearing it
   // on reset is cheap and guarantees no stale samples survive a mid-frame reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         dout_r    <= '0;
         dout_i    <= '0;
         for (int i = 0; i < DELAY; i++) begin
            dl_r[i] <= '0;
            dl_i[i] <= '0;
         end
      end else begin
         // NOTE: non-blocking assignments so every stage of the chain shifts
         // from its pre-edge value regardless of statement order.
         out_valid <= 1'b0;
         if (in_valid) begin
            out_valid <= nxt_valid;
            dout_r    <= nxt_r;
            dout_i    <= nxt_i;
            dl_r[0]   <= push_r;
            dl_i[0]   <= push_i;
            for (int i = 1; i < DELAY; i++) begin
               dl_r[i] <= dl_r[i-1];
               dl_i[i] <= dl_i[i-1];
            end
         end
      end
   end

endmodule

// File: tb/tb_sdf_bf_stage.sv
// Directed bench for sdf_bf_stage with DELAY=2, W=24: prime/butterfly,
// rotation, wrap-around, stall, truncation and reset behaviour.
module tb_sdf_bf_stage;
   import sdf_bf_stage_pkg::*;

   localparam int TW = 24;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic                 in_valid = 1'b0;
   logic signed [TW-1:0] din_r = '0, din_i = '0;
   logic        [1:0]    state = 2'd0;
   logic signed [TW-1:0] w_r = '0, w_i = '0;
   logic                 out_valid;
   logic signed [TW-1:0] dout_r, dout_i;

   int n_checks = 0;
   int n_fail   = 0;

   sdf_bf_stage #(.DELAY(2), .W(TW)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .din_r     (din_r),
      .din_i     (din_i),
      .state     (state),
      .w_r       (w_r),
      .w_i       (w_i),
      .out_valid (out_valid),
      .dout_r    (dout_r),
      .dout_i    (dout_i)
   );

   always #5 clk = ~clk;

   // One advancing cycle; outputs are sampled 1 time unit after the edge.
   task automatic step(input logic [1:0] st, input logic [TW-1:0] dr, input logic [TW-1:0] di,
                       input logic [TW-1:0] wr, input logic [TW-1:0] wi);
      in_valid = 1'b1;
      state    = st;
      din_r    = dr;
      din_i    = di;
      w_r      = wr;
      w_i      = wi;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #2;
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL reset_valid: got %0b expected 0", out_valid);
      end
      n_checks++;
      if (dout_r !== 24'h000000) begin
         n_fail++; $display("FAIL reset_dout_r: got %h expected 000000", dout_r);
      end
      n_checks++;
      if (dout_i !== 24'h000000) begin
         n_fail++; $display("FAIL reset_dout_i: got %h expected 000000", dout_i);
      end
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      // Butterfly straight after reset: head must be zero, so dout equals din.
      step(BFLY, 24'h000100, 24'h000020, ONE, 24'h0);
      n_checks++;
      if (dout_r !== 24'h000100 || dout_i !== 24'h000020 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_residual: got %h/%h v%0b expected 000100/000020 v1", dout_r, dout_i, out_valid);
      end
   endtask

   task automatic test_prime_bfly();
      do_reset();
      step(PRIME, 24'h000100, 24'h0, ONE, 24'h0);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL prime1_valid: got %0b expected 0", out_valid);
      end
      step(PRIME, 24'h000200, 24'h0, ONE, 24'h0);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL prime2_valid: got %0b expected 0", out_valid);
      end
      step(BFLY, 24'h000300, 24'h0, ONE, 24'h0);
      n_checks++;
      if (dout_r !== 24'h000400 || dout_i !== 24'h0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bfly1: got %h/%h v%0b expected 000400/000000 v1", dout_r, dout_i, out_valid);
      end
      step(BFLY, 24'h000400, 24'h0, ONE, 24'h0);
      n_checks++;
      if (dout_r !== 24'h000600 || dout_i !== 24'h0 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL bfly2: got %h/%h v%0b expected 000600/000000 v1", dout_r, dout_i, out_valid);
      end
   endtask

   // Continues from test_prime_bfly: the line holds two differences of -2.0.
   task automatic test_rotate();
      for (int k = 0; k < 2; k++) begin
         step(ROTATE, 24'h0, 24'h0, 24'h0, NEG_ONE);
         n_checks++;
         if (dout_r !== 24'h000000 || dout_i !== 24'h000200 || out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rotate%0d: got %h/%h v%0b expected 000000/000200 v1", k, dout_r, dout_i, out_valid);
         end
      end
   endtask

   task automatic test_reserved_state();
      // Reserved code primes: no output, and the pushed value must be din itself.
      do_reset();
      step(RSVD, 24'h000300, 24'h000100, ONE, 24'h0);
      n_checks++;
      if (out_valid !== 1'b0) begin
         n_fail++; $display("FAIL rsvd_valid: got %0b expected 0", out_valid);
      end
      step(RSVD, 24'h000500, 24'h0, ONE, 24'h0);
      step(ROTATE, 24'h0, 24'h0, ONE, 24'h0);
      n_checks++;
      if (dout_r !== 24'h000300 || dout_i !== 24'h000100 || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL rsvd_push: got %h/%h v%0b expected 000300/000100 v1", dout_r, dout_i, out_valid);
      end
   endtask

   task automatic test_wrap();
      do_reset();
      step(PRIME, 24'h7FFF00, 24'h0, ONE, 24'h0);
      step(PRIME, 24'h000000, 24'h0, ONE, 24'h0);
      step(BFLY, 24'h000200, 24'h0, ONE, 24'h0);
      n_checks++;
      if (dout_r !== 24'h800100) begin
         n_fail++; $display("FAIL wrap_sum: got %h expected 800100", dout_r);
      end
      step(BFLY, 24'h000000, 24'h0, ONE, 24'h0);
      // Rotating by 1.0 exposes the pushed difference unchanged.
      step(ROTATE, 24'h0, 24'h0, ONE, 24'h0);
      n_checks++;
      if (dout_r !== 24'h7FFD00 || dout_i !== 24'h0) begin
         n_fail++; $display("FAIL wrap_diff: got %h/%h expected 7FFD00/000000", dout_r, dout_i);
      end
   endtask

   task automatic test_stall();
      do_reset();
      step(PRIME, 24'h000100, 24'h0, ONE, 24'h0);
      step(PRIME, 24'h000200, 24'h0, ONE, 24'h0);
      step(BFLY, 24'h000300, 24'h0, ONE, 24'h0);
      n_checks++;
      if (dout_r !== 24'h000400 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL stall_pre: got %h v%0b expected 000400 v1", dout_r, out_valid);
      end
      in_valid = 1'b0;
      state    = BFLY;
      din_r    = 24'h123400;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
         n_checks++;
         if (out_valid !== 1'b0 || dout_r !== 24'h000400 || dout_i !== 24'h0) begin
            n_fail++;
            $display("FAIL stall_hold%0d: got %h/%h v%0b expected 000400/000000 v0", k, dout_r, dout_i, out_valid);
         end
      end
      step(BFLY, 24'h000400, 24'h0, ONE, 24'h0);
      n_checks++;
      if (dout_r !== 24'h000600 || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL stall_resume: got %h v%0b expected 000600 v1", dout_r, out_valid);
      end
      test_rotate();
   endtask

   task automatic test_truncation();
      do_reset();
      step(PRIME, 24'h000001, 24'h0, ONE, 24'h0);
      step(PRIME, 24'hFFFFFF, 24'h0, ONE, 24'h0);
      step(ROTATE, 24'h0, 24'h0, 24'h000080, 24'h0);
      n_checks++;
      if (dout_r !== 24'h000000 || dout_i !== 24'h000000) begin
         n_fail++; $display("FAIL trunc_pos: got %h/%h expected 000000/000000", dout_r, dout_i);
      end
      step(ROTATE, 24'h0, 24'h0, 24'h000080, 24'h0);
      n_checks++;
      if (dout_r !== 24'hFFFFFF || dout_i !== 24'h000000) begin
         n_fail++; $display("FAIL trunc_neg: got %h/%h expected FFFFFF/000000", dout_r, dout_i);
      end
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      step(PRIME, 24'h000100, 24'h0, ONE, 24'h0);
      step(PRIME, 24'h000200, 24'h0, ONE, 24'h0);
      step(BFLY, 24'h000300, 24'h0, ONE, 24'h0);
      rst_n = 1'b0;
      #1;
      n_checks++;
      if (out_valid !== 1'b0 || dout_r !== 24'h0 || dout_i !== 24'h0) begin
         n_fail++;
         $display("FAIL midreset_clear: got %h/%h v%0b expected 000000/000000 v0", dout_r, dout_i, out_valid);
      end
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      test_prime_bfly();
      test_rotate();
   endtask

   task automatic test_back_to_back();
      // Consecutive valid cycles with no gaps: one result per cycle.
      do_reset();
      step(PRIME, 24'h000010, 24'h000001, ONE, 24'h0);
      step(PRIME, 24'h000020, 24'h000002, ONE, 24'h0);
      step(BFLY, 24'h000005, 24'h000003, ONE, 24'h0);
      n_checks++;
      if (dout_r !== 24'h000015 || dout_i !== 24'h000004) begin
         n_fail++; $display("FAIL b2b_0: got %h/%h expected 000015/000004", dout_r, dout_i);
      end
      step(BFLY, 24'h000030, 24'h000001, ONE, 24'h0);
      n_checks++;
      if (dout_r !== 24'h000050 || dout_i !== 24'h000003) begin
         n_fail++; $display("FAIL b2b_1: got %h/%h expected 000050/000003", dout_r, dout_i);
      end
      // Head is (0x10-0x05, 0x01-0x03) = (0x0B, -2); rotate by j gives (2, 0x0B).
      step(ROTATE, 24'h0, 24'h0, 24'h0, ONE);
      n_checks++;
      if (dout_r !== 24'h000002 || dout_i !== 24'h00000B || out_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_rot: got %h/%h v%0b expected 000002/00000B v1", dout_r, dout_i, out_valid);
      end
   endtask

   initial begin
      test_reset();
      test_prime_bfly();
      test_rotate();
      test_reserved_state();
      test_wrap();
      test_stall();
      test_truncation();
      test_reset_mid_frame();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
